// File: rtl/svm_pe_mac.sv
// Three-stage fixed-point MAC for the SVM stage: o_data = i_data + dot(36 features, 36 weights).
// Define SVM_PE_SAT_EN to saturate the result to W bits; otherwise the result wraps.
module svm_pe_mac #(
  parameter int FEA_I = 4,
  parameter int FEA_F = 28,
  localparam int W = FEA_I + FEA_F
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [9*W-1:0] fea_a,
  input  logic [9*W-1:0] fea_b,
  input  logic [9*W-1:0] fea_c,
  input  logic [9*W-1:0] fea_d,
  input  logic [9*W-1:0] coef_a,
  input  logic [9*W-1:0] coef_b,
  input  logic [9*W-1:0] coef_c,
  input  logic [9*W-1:0] coef_d,
  input  logic [W-1:0]   i_data,
  input  logic           i_valid,
  output logic [W-1:0]   o_data,
  output logic           o_valid
);

  localparam int N  = 36;
  localparam int PW = 2 * W;
  localparam int CW = PW + 4;
  localparam int AW = PW + 6;

  logic [N*W-1:0]        fea_all;
  logic [N*W-1:0]        coef_all;

  logic signed [PW-1:0]  prod_d [N];
  logic signed [PW-1:0]  prod_q [N];
  logic signed [W-1:0]   idata1_d, idata1_q;
  logic                  valid1_d, valid1_q;

  logic signed [CW-1:0]  cell_d [4];
  logic signed [CW-1:0]  cell_q [4];
  logic signed [CW-1:0]  acc;
  logic signed [W-1:0]   idata2_d, idata2_q;
  logic                  valid2_d, valid2_q;

  logic signed [AW-1:0]  sum;
  logic [W-1:0]          res;
  logic [W-1:0]          o_data_d, o_data_q;
  logic                  o_valid_d, o_valid_q;
  logic                  unused_bits;

  always_comb begin
    fea_all  = {fea_d, fea_c, fea_b, fea_a};
    coef_all = {coef_d, coef_c, coef_b, coef_a};
  end

  // S1: full-precision products; registers hold on bubbles
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      prod_d[i] = prod_q[i];
      if (i_valid)
        prod_d[i] = PW'($signed(fea_all[i*W +: W])) * PW'($signed(coef_all[i*W +: W]));
    end
    idata1_d = i_valid ? $signed(i_data) : idata1_q;
    valid1_d = i_valid;
  end

  // S2: one 9-term sum per cell
  always_comb begin
    acc = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      acc = '0;
      for (int unsigned k = 0; k < 9; k++)
        acc = acc + CW'(prod_q[c*9 + k]);
      cell_d[c] = valid1_q ? acc : cell_q[c];
    end
    idata2_d = valid1_q ? idata1_q : idata2_q;
    valid2_d = valid1_q;
  end

  // S3: align partial sum to product scale, add, then drop FEA_F bits (floor)
  always_comb begin
    sum = AW'(idata2_q) <<< FEA_F;
    for (int unsigned c = 0; c < 4; c++)
      sum = sum + AW'(cell_q[c]);
`ifdef SVM_PE_SAT_EN
    // in range only when every bit from W-1 upward of the shifted sum agrees
    if ((&sum[AW-1:FEA_F+W-1]) || !(|sum[AW-1:FEA_F+W-1]))
      res = sum[FEA_F +: W];
    else if (sum[AW-1])
      res = {1'b1, {(W-1){1'b0}}};
    else
      res = {1'b0, {(W-1){1'b1}}};
    unused_bits = ^sum[FEA_F-1:0];
`else
    res = sum[FEA_F +: W];
    unused_bits = ^{sum[FEA_F-1:0], sum[AW-1:FEA_F+W]};
`endif
    o_data_d  = valid2_q ? res : o_data_q;
    o_valid_d = valid2_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < N; i++) prod_q[i] <= '0;
      for (int unsigned c = 0; c < 4; c++) cell_q[c] <= '0;
      idata1_q  <= '0;
      valid1_q  <= 1'b0;
      idata2_q  <= '0;
      valid2_q  <= 1'b0;
      o_data_q  <= '0;
      o_valid_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < N; i++) prod_q[i] <= prod_d[i];
      for (int unsigned c = 0; c < 4; c++) cell_q[c] <= cell_d[c];
      idata1_q  <= idata1_d;
      valid1_q  <= valid1_d;
      idata2_q  <= idata2_d;
      valid2_q  <= valid2_d;
      o_data_q  <= o_data_d;
      o_valid_q <= o_valid_d;
    end
  end

  assign o_data  = o_data_q;
  assign o_valid = o_valid_q;

endmodule

// File: tb/tb_svm_pe_mac.sv
// Directed table-driven bench for svm_pe_mac at default parameters (Q4.28).
module tb_svm_pe_mac;

  localparam int W = 32;
`ifdef SVM_PE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [36*W-1:0] fea_all = '0;
  logic [36*W-1:0] coef_all = '0;
  logic [W-1:0]   i_data = '0;
  logic           i_valid = 1'b0;
  logic [W-1:0]   o_data;
  logic           o_valid;

  always #5 clk = ~clk;

  svm_pe_mac #(.FEA_I(4), .FEA_F(28)) dut (
    .clk    (clk),
    .rst    (rst),
    .fea_a  (fea_all[0*9*W +: 9*W]),
    .fea_b  (fea_all[1*9*W +: 9*W]),
    .fea_c  (fea_all[2*9*W +: 9*W]),
    .fea_d  (fea_all[3*9*W +: 9*W]),
    .coef_a (coef_all[0*9*W +: 9*W]),
    .coef_b (coef_all[1*9*W +: 9*W]),
    .coef_c (coef_all[2*9*W +: 9*W]),
    .coef_d (coef_all[3*9*W +: 9*W]),
    .i_data (i_data),
    .i_valid(i_valid),
    .o_data (o_data),
    .o_valid(o_valid)
  );

  typedef struct {
    int          fidx;   // -1: every bin of every cell, else one bin index 0..35
    logic [31:0] fval;
    logic [31:0] cval;
    logic [31:0] idata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [10];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    for (int i = 0; i < 36; i++) begin
      fea_all[i*W +: W]  = (v.fidx < 0 || v.fidx == i) ? v.fval : 32'h0;
      coef_all[i*W +: W] = (v.fidx < 0 || v.fidx == i) ? v.cval : 32'h0;
    end
    i_data = v.idata;
  endtask

  task automatic drive_idata(input logic [31:0] d, input logic v);
    fea_all  = '0;
    coef_all = '0;
    i_data   = d;
    i_valid  = v;
  endtask

  initial begin
    vecs[0] = '{0,  32'h20000000, 32'h18000000, 32'hF0000000, 32'h20000000};
    vecs[1] = '{-1, 32'h04000000, 32'hF8000000, 32'h00000000, 32'hB8000000};
    vecs[2] = '{-1, 32'h10000000, 32'h04000000, 32'h00000000, SAT ? 32'h7FFFFFFF : 32'h90000000};
    vecs[3] = '{20, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF};
    vecs[4] = '{35, 32'h10000000, 32'h10000000, 32'h08000000, 32'h18000000};
    vecs[5] = '{-1, 32'h00000000, 32'h00000000, 32'h12345678, 32'h12345678};
    vecs[6] = '{-1, 32'h10000000, 32'hFC000000, 32'h00000000, SAT ? 32'h80000000 : 32'h70000000};
    vecs[7] = '{9,  32'hF0000000, 32'hF0000000, 32'hF8000000, 32'h08000000};
    vecs[8] = '{-1, 32'h00000000, 32'h00000000, 32'h7FFFFFFF, 32'h7FFFFFFF};
    vecs[9] = '{0,  32'h10000000, 32'h00000001, 32'h7FFFFFFF, SAT ? 32'h7FFFFFFF : 32'h80000000};

    // reset state
    #2;
    chk("rst_o_valid", {31'b0, o_valid}, 32'h0);
    chk("rst_o_data", o_data, 32'h0);
    step();
    step();
    rst = 1'b1;
    step();

    // single beats: latency exactly 3 edges, then hold on the following bubble
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i]);
      i_valid = 1'b1;
      step();
      i_valid = 1'b0;
      chk($sformatf("v%0d_lat1", i), {31'b0, o_valid}, 32'h0);
      step();
      chk($sformatf("v%0d_lat2", i), {31'b0, o_valid}, 32'h0);
      step();
      chk($sformatf("v%0d_valid", i), {31'b0, o_valid}, 32'h1);
      chk($sformatf("v%0d_data", i), o_data, vecs[i].exp);
      step();
      chk($sformatf("v%0d_drop", i), {31'b0, o_valid}, 32'h0);
      chk($sformatf("v%0d_hold", i), o_data, vecs[i].exp);
    end

    // back-to-back stream of the whole table
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i]);
      i_valid = 1'b1;
      step();
      if (i >= 2) begin
        chk($sformatf("s%0d_valid", i - 2), {31'b0, o_valid}, 32'h1);
        chk($sformatf("s%0d_data", i - 2), o_data, vecs[i - 2].exp);
      end
    end
    i_valid = 1'b0;
    step();
    chk("s8_valid", {31'b0, o_valid}, 32'h1);
    chk("s8_data", o_data, vecs[8].exp);
    step();
    chk("s9_valid", {31'b0, o_valid}, 32'h1);
    chk("s9_data", o_data, vecs[9].exp);
    step();
    chk("s_end_valid", {31'b0, o_valid}, 32'h0);

    // valid pattern 1,1,0,1 with i_data 1.0, 2.0, 3.0, 4.0
    drive_idata(32'h10000000, 1'b1); step();
    drive_idata(32'h20000000, 1'b1); step();
    drive_idata(32'h30000000, 1'b0); step();
    chk("b_c3_valid", {31'b0, o_valid}, 32'h1);
    chk("b_c3_data", o_data, 32'h10000000);
    drive_idata(32'h40000000, 1'b1); step();
    chk("b_c4_valid", {31'b0, o_valid}, 32'h1);
    chk("b_c4_data", o_data, 32'h20000000);
    drive_idata(32'h0, 1'b0); step();
    chk("b_c5_valid", {31'b0, o_valid}, 32'h0);
    chk("b_c5_hold", o_data, 32'h20000000);
    step();
    chk("b_c6_valid", {31'b0, o_valid}, 32'h1);
    chk("b_c6_data", o_data, 32'h40000000);
    step();
    chk("b_c7_valid", {31'b0, o_valid}, 32'h0);
    chk("b_c7_hold", o_data, 32'h40000000);

    // reset mid-flight: one beat at the output, two more in the pipe
    drive_idata(32'h11000000, 1'b1); step();
    drive_idata(32'h22000000, 1'b1); step();
    drive_idata(32'h33000000, 1'b1); step();
    i_valid = 1'b0;
    chk("r_pre_valid", {31'b0, o_valid}, 32'h1);
    chk("r_pre_data", o_data, 32'h11000000);
    #1 rst = 1'b0;
    #1;
    chk("r_async_valid", {31'b0, o_valid}, 32'h0);
    chk("r_async_data", o_data, 32'h0);
    step();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("r_nostale%0d", i), {31'b0, o_valid}, 32'h0);
    end
    chk("r_post_data", o_data, 32'h0);
    drive_idata(32'h05000000, 1'b1); step();
    i_valid = 1'b0;
    step();
    chk("r_new_lat2", {31'b0, o_valid}, 32'h0);
    step();
    chk("r_new_valid", {31'b0, o_valid}, 32'h1);
    chk("r_new_data", o_data, 32'h05000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
